swervolf_wb_ram_arb: RTL and testbench

Wishbone classic arbiter that shares the single on-chip RAM slave in swervolf_core between NM masters. Typical masters are the core data bus and a DMA/debug loader. Arbitration is round-robin, and ownership is held for the whole owner cycle (cyc held high). A per-access watchdog returns a bus error if the RAM never acks, so a hung slave cannot lock out the other masters.

---
 rtl/swervolf_arb_pkg.sv | 25 ++
 rtl/swervolf_rr_pick.sv | 39 +++
 rtl/swervolf_wb_ram_arb.sv | 147 ++++++++++++++
 tb/tb_swervolf_wb_ram_arb.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/swervolf_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : swervolf_arb_pkg
// Brief    : Shared state encoding and sizing helpers for the RAM arbiter.
// Revision : 1.0
// ============================================================================
package swervolf_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_ERR  = 2'd2
    } arb_state_e;

    localparam logic [1:0] c_st_idle = 2'(ARB_IDLE);
    localparam logic [1:0] c_st_busy = 2'(ARB_BUSY);
    localparam logic [1:0] c_st_err  = 2'(ARB_ERR);

    // A single master still needs a 1-bit owner register.
    function automatic int owner_width(input int nm);
        return (nm > 1) ? $clog2(nm) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/swervolf_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : swervolf_rr_pick
// Brief    : Combinational round-robin picker, searching from last+1 mod NM.
// Revision : 1.0
// ============================================================================
module swervolf_rr_pick
    import swervolf_arb_pkg::*;
#(
    parameter int NM = 2,
    localparam int OW = owner_width(NM)
) (
    input  logic [NM-1:0] req,
    input  logic [OW-1:0] last,
    output logic          valid,
    output logic [OW-1:0] idx
);

    int              w_cand;
    logic [OW-1:0]   w_cand_idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        valid      = 1'b0;
        idx        = '0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int k = NM; k >= 1; k--) begin
            w_cand     = (int'(last) + k) % NM;
            w_cand_idx = OW'(w_cand);
            if (req[w_cand_idx]) begin
                valid = 1'b1;
                idx   = w_cand_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/swervolf_wb_ram_arb.sv
`default_nettype none
// ============================================================================
// Module   : swervolf_wb_ram_arb
// Brief    : Round-robin Wishbone classic arbiter for the shared on-chip RAM,
//            with per-access watchdog returning a bus error on a hung slave.
// Revision : 1.0
// ============================================================================
module swervolf_wb_ram_arb
    import swervolf_arb_pkg::*;
#(
    parameter int NM      = 2,
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    localparam int SW     = DW / 8,
    localparam int OW     = owner_width(NM)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NM*AW-1:0] i_m_adr,
    input  logic [NM*DW-1:0] i_m_dat,
    input  logic [NM*SW-1:0] i_m_sel,
    input  logic [NM-1:0]    i_m_we,
    input  logic [NM-1:0]    i_m_cyc,
    input  logic [NM-1:0]    i_m_stb,
    output logic [DW-1:0]    o_m_rdt,
    output logic [NM-1:0]    o_m_ack,
    output logic [NM-1:0]    o_m_err,
    output logic [AW-1:0]    o_s_adr,
    output logic [DW-1:0]    o_s_dat,
    output logic [SW-1:0]    o_s_sel,
    output logic             o_s_we,
    output logic             o_s_cyc,
    output logic             o_s_stb,
    input  logic [DW-1:0]    i_s_rdt,
    input  logic             i_s_ack
);

    logic [1:0]    r_state;
    logic [OW-1:0] r_owner;
    logic [OW-1:0] r_last;

    logic          w_pick_valid;
    logic [OW-1:0] w_pick_idx;
    logic          w_own_cyc;
    logic          w_own_stb;
    logic          w_own_we;
    logic          w_wd_fire;

    swervolf_rr_pick #(
        .NM    (NM)
    ) u_pick (
        .req   (i_m_cyc),
        .last  (r_last),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    assign w_own_cyc = i_m_cyc[r_owner];
    assign w_own_stb = i_m_stb[r_owner];
    assign w_own_we  = i_m_we[r_owner];
    assign o_m_rdt   = i_s_rdt;

    generate
        if (TIMEOUT > 0) begin : g_wdog
            localparam int CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] c_wd_last = CW'(TIMEOUT - 1);
            logic [CW-1:0] r_wd_cnt;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_wd_cnt <= '0;
                end else if (r_state != c_st_busy || i_s_ack || !w_own_stb || !w_own_cyc) begin
                    r_wd_cnt <= '0;
                end else begin
                    r_wd_cnt <= r_wd_cnt + 1'b1;
                end
            end

            assign w_wd_fire = (r_state == c_st_busy) && w_own_cyc && w_own_stb &&
                               !i_s_ack && (r_wd_cnt == c_wd_last);
        end else begin : g_no_wdog
            assign w_wd_fire = 1'b0;
        end
    endgenerate

    // Slave side is driven only while an owner holds the bus; ERR aborts it.
    always_comb begin
        o_s_cyc = 1'b0;
        o_s_stb = 1'b0;
        o_s_we  = 1'b0;
        o_s_adr = '0;
        o_s_dat = '0;
        o_s_sel = '0;
        o_m_ack = '0;
        o_m_err = '0;
        case (r_state)
            c_st_busy: begin
                o_s_cyc          = w_own_cyc;
                o_s_stb          = w_own_cyc & w_own_stb;
                o_s_we           = w_own_cyc & w_own_we;
                o_s_adr          = i_m_adr[r_owner*AW +: AW];
                o_s_dat          = i_m_dat[r_owner*DW +: DW];
                o_s_sel          = i_m_sel[r_owner*SW +: SW];
                o_m_ack[r_owner] = i_s_ack;
            end
            c_st_err: begin
                o_m_err[r_owner] = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_st_idle;
            r_owner <= '0;
            r_last  <= OW'(NM - 1);
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_pick_valid) begin
                        r_owner <= w_pick_idx;
                        r_last  <= w_pick_idx;
                        r_state <= c_st_busy;
                    end
                end
                c_st_busy: begin
                    if (!w_own_cyc) begin
                        r_state <= c_st_idle;
                    end else if (w_wd_fire) begin
                        r_state <= c_st_err;
                    end
                end
                c_st_err: begin
                    r_state <= w_own_cyc ? c_st_busy : c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_swervolf_wb_ram_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_swervolf_wb_ram_arb
// Brief    : Scenario bench for the RAM arbiter (watchdog and no-watchdog builds).
// Revision : 1.0
// ============================================================================
module tb_swervolf_wb_ram_arb;

    localparam int NM = 2;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NM*AW-1:0]  m_adr;
    logic [NM*DW-1:0]  m_dat;
    logic [NM*SW-1:0]  m_sel;
    logic [NM-1:0]     m_we, m_cyc, m_stb;
    logic [DW-1:0]     m_rdt;
    logic [NM-1:0]     m_ack, m_err;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dat;
    logic [SW-1:0]     s_sel;
    logic              s_we, s_cyc, s_stb;
    logic [DW-1:0]     s_rdt;
    logic              s_ack;

    logic [NM*AW-1:0]  b_m_adr;
    logic [NM*DW-1:0]  b_m_dat;
    logic [NM*SW-1:0]  b_m_sel;
    logic [NM-1:0]     b_m_we, b_m_cyc, b_m_stb;
    logic [DW-1:0]     b_m_rdt;
    logic [NM-1:0]     b_m_ack, b_m_err;
    logic [AW-1:0]     b_s_adr;
    logic [DW-1:0]     b_s_dat;
    logic [SW-1:0]     b_s_sel;
    logic              b_s_we, b_s_cyc, b_s_stb;
    logic [DW-1:0]     b_s_rdt;
    logic              b_s_ack;

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] exp_adr_q[$];
    logic [DW-1:0] exp_dat_q[$];

    always #5 clk = ~clk;

    swervolf_wb_ram_arb #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .clk(clk), .rstn(rstn),
        .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel), .i_m_we(m_we),
        .i_m_cyc(m_cyc), .i_m_stb(m_stb),
        .o_m_rdt(m_rdt), .o_m_ack(m_ack), .o_m_err(m_err),
        .o_s_adr(s_adr), .o_s_dat(s_dat), .o_s_sel(s_sel), .o_s_we(s_we),
        .o_s_cyc(s_cyc), .o_s_stb(s_stb),
        .i_s_rdt(s_rdt), .i_s_ack(s_ack)
    );

    swervolf_wb_ram_arb #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(0)) dut_b (
        .clk(clk), .rstn(rstn),
        .i_m_adr(b_m_adr), .i_m_dat(b_m_dat), .i_m_sel(b_m_sel), .i_m_we(b_m_we),
        .i_m_cyc(b_m_cyc), .i_m_stb(b_m_stb),
        .o_m_rdt(b_m_rdt), .o_m_ack(b_m_ack), .o_m_err(b_m_err),
        .o_s_adr(b_s_adr), .o_s_dat(b_s_dat), .o_s_sel(b_s_sel), .o_s_we(b_s_we),
        .o_s_cyc(b_s_cyc), .o_s_stb(b_s_stb),
        .i_s_rdt(b_s_rdt), .i_s_ack(b_s_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the next grant on dut; reports the granted address and idle cycles seen.
    task automatic wait_grant(output logic [AW-1:0] adr, output int idle, output bit ok);
        idle = 0;
        ok   = 1'b1;
        @(negedge clk);
        while (!s_cyc) begin
            idle++;
            if (idle > 20) begin
                ok = 1'b0;
                break;
            end
            @(negedge clk);
        end
        adr = s_adr;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
        s_rdt = '0; s_ack = 1'b1;
        b_m_adr = '0; b_m_dat = '0; b_m_sel = '0; b_m_we = '0; b_m_cyc = '0; b_m_stb = '0;
        b_s_rdt = '0; b_s_ack = 1'b0;
        #23;
        checks++;
        if ({s_cyc, s_stb, s_we} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl got %b expected 000", {s_cyc, s_stb, s_we});
        end
        checks++;
        if ({s_adr, s_dat, s_sel} !== '0) begin
            errors++; $display("FAIL reset_bus got %h/%h/%h expected 0", s_adr, s_dat, s_sel);
        end
        checks++;
        if ({m_ack, m_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_ackerr got %b expected 0000", {m_ack, m_err});
        end
        s_ack = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] got;
        logic [AW-1:0] exp;
        logic [DW-1:0] expd;
        logic [1:0]    exp_ack;
        int idle, owner;
        bit ok;
        tick();
        m_adr[0 +: AW] = 16'h0100;
        m_adr[AW +: AW] = 16'h0200;
        m_sel = '1;
        m_cyc = 2'b11; m_stb = 2'b11;
        exp_adr_q.push_back(16'h0100); exp_adr_q.push_back(16'h0200);
        exp_adr_q.push_back(16'h0100); exp_adr_q.push_back(16'h0200);
        for (int t = 0; t < 4; t++) begin
            wait_grant(got, idle, ok);
            exp = exp_adr_q.pop_front();
            checks++;
            if (!ok) begin
                errors++; $display("FAIL rr_grant_timeout txn %0d s_cyc never rose", t);
            end
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL rr_order txn %0d got adr %h expected %h", t, got, exp);
            end
            checks++;
            if (idle !== 1) begin
                errors++; $display("FAIL rr_idle txn %0d got %0d idle cycles expected 1", t, idle);
            end
            owner = (got == 16'h0200) ? 1 : 0;
            tick();
            s_ack = 1'b1; s_rdt = 32'h1000 + t;
            exp_dat_q.push_back(32'h1000 + t);
            @(negedge clk);
            exp_ack = 2'(1 << owner);
            expd = exp_dat_q.pop_front();
            checks++;
            if (m_ack !== exp_ack || m_rdt !== expd) begin
                errors++; $display("FAIL rr_ack txn %0d got %b/%h expected %b/%h", t, m_ack, m_rdt, exp_ack, expd);
            end
            tick();
            s_ack = 1'b0;
            m_cyc[owner] = 1'b0; m_stb[owner] = 1'b0;
            if (t == 3) begin
                m_cyc = '0; m_stb = '0;
            end
            @(negedge clk);
            checks++;
            if (s_cyc !== 1'b0) begin
                errors++; $display("FAIL rr_release txn %0d got s_cyc %b expected 0", t, s_cyc);
            end
            tick();
            if (t < 3) begin
                m_cyc[owner] = 1'b1; m_stb[owner] = 1'b1;
            end
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] expd;
        logic [AW-1:0] exp;
        tick();
        m_adr[0 +: AW] = 16'h0040; m_we = '0;
        m_cyc = 2'b01; m_stb = 2'b01;
        exp_adr_q.push_back(16'h0040);
        @(negedge clk);
        checks++;
        if (s_stb !== 1'b0) begin
            errors++; $display("FAIL single_latency got s_stb %b expected 0", s_stb);
        end
        tick();
        @(negedge clk);
        exp = exp_adr_q.pop_front();
        checks++;
        if (s_stb !== 1'b1 || s_adr !== exp) begin
            errors++; $display("FAIL single_stb got %b/%h expected 1/%h", s_stb, s_adr, exp);
        end
        tick();
        @(negedge clk);
        checks++;
        if (m_ack !== 2'b00) begin
            errors++; $display("FAIL single_early_ack got %b expected 00", m_ack);
        end
        tick();
        s_ack = 1'b1; s_rdt = 32'hDEADBEEF;
        exp_dat_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        expd = exp_dat_q.pop_front();
        checks++;
        if (m_ack !== 2'b01 || m_rdt !== expd) begin
            errors++; $display("FAIL single_ack got %b/%h expected 01/%h", m_ack, m_rdt, expd);
        end
        tick();
        s_ack = 1'b0; m_cyc = '0; m_stb = '0;
        @(negedge clk);
        checks++;
        if (m_ack !== 2'b00 || s_cyc !== 1'b0) begin
            errors++; $display("FAIL single_end got ack %b cyc %b expected 00/0", m_ack, s_cyc);
        end
        tick();
    endtask

    task automatic test_block();
        logic [AW-1:0] got;
        logic [AW-1:0] exp;
        logic [DW-1:0] expd;
        int idle;
        bit ok;
        tick();
        m_adr[AW +: AW] = 16'h0300; m_we = 2'b10;
        m_cyc = 2'b10; m_stb = 2'b10;
        @(negedge clk);
        tick();
        m_adr[0 +: AW] = 16'h0080;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        exp_adr_q.push_back(16'h0080);
        for (int i = 0; i < 4; i++) begin
            m_dat[DW +: DW] = 32'hA000_0000 + i;
            s_ack = 1'b1;
            exp_dat_q.push_back(32'hA000_0000 + i);
            @(negedge clk);
            expd = exp_dat_q.pop_front();
            checks++;
            if (s_adr !== 16'h0300 || s_we !== 1'b1 || s_dat !== expd || m_ack !== 2'b10) begin
                errors++;
                $display("FAIL block_write %0d got adr %h we %b dat %h ack %b expected 0300/1/%h/10",
                         i, s_adr, s_we, s_dat, m_ack, expd);
            end
            tick();
        end
        s_ack = 1'b0;
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_we = '0;
        @(negedge clk);
        checks++;
        if (s_cyc !== 1'b0) begin
            errors++; $display("FAIL block_release got s_cyc %b expected 0", s_cyc);
        end
        tick();
        wait_grant(got, idle, ok);
        exp = exp_adr_q.pop_front();
        checks++;
        if (!ok || got !== exp || idle !== 1) begin
            errors++; $display("FAIL block_handover got adr %h idle %0d ok %0d expected %h/1/1", got, idle, ok, exp);
        end
        tick();
        s_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (m_ack !== 2'b01) begin
            errors++; $display("FAIL block_m0_ack got %b expected 01", m_ack);
        end
        tick();
        s_ack = 1'b0; m_cyc = '0; m_stb = '0;
        @(negedge clk);
        tick();
    endtask

    task automatic test_watchdog();
        logic [AW-1:0] got;
        logic [AW-1:0] exp;
        int idle;
        bit ok;
        tick();
        m_adr[0 +: AW] = 16'h0500;
        m_cyc = 2'b01; m_stb = 2'b01;
        @(negedge clk);
        tick();
        m_adr[AW +: AW] = 16'h0600;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        exp_adr_q.push_back(16'h0600);
        for (int n = 0; n < 8; n++) begin
            if (n > 0) tick();
            @(negedge clk);
            checks++;
            if (s_stb !== 1'b1 || m_err !== 2'b00 || s_adr !== 16'h0500) begin
                errors++; $display("FAIL wdog_stall cycle %0d got stb %b err %b adr %h expected 1/00/0500", n, s_stb, m_err, s_adr);
            end
        end
        tick();
        s_ack = 1'b1;
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (m_err !== 2'b01 || m_ack !== 2'b00 || s_stb !== 1'b0 || s_cyc !== 1'b0) begin
            errors++; $display("FAIL wdog_err got err %b ack %b stb %b cyc %b expected 01/00/0/0", m_err, m_ack, s_stb, s_cyc);
        end
        tick();
        s_ack = 1'b0;
        wait_grant(got, idle, ok);
        exp = exp_adr_q.pop_front();
        checks++;
        if (!ok || got !== exp || idle !== 1) begin
            errors++; $display("FAIL wdog_next_grant got adr %h idle %0d ok %0d expected %h/1/1", got, idle, ok, exp);
        end
        tick();
        s_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (m_ack !== 2'b10 || m_err !== 2'b00) begin
            errors++; $display("FAIL wdog_m1_ack got ack %b err %b expected 10/00", m_ack, m_err);
        end
        tick();
        s_ack = 1'b0; m_cyc = '0; m_stb = '0;
        @(negedge clk);
        tick();
    endtask

    task automatic test_no_timeout();
        logic [DW-1:0] expd;
        bit err_seen;
        bit stb_lost;
        err_seen = 1'b0;
        stb_lost = 1'b0;
        tick();
        b_m_adr[0 +: AW] = 16'h0700;
        b_m_cyc = 2'b01; b_m_stb = 2'b01;
        @(negedge clk);
        for (int n = 0; n < 300; n++) begin
            tick();
            @(negedge clk);
            if (b_m_err !== 2'b00) err_seen = 1'b1;
            if (b_s_stb !== 1'b1) stb_lost = 1'b1;
        end
        checks++;
        if (err_seen || stb_lost) begin
            errors++; $display("FAIL nowdog_stall got err_seen %0d stb_lost %0d expected 0/0", err_seen, stb_lost);
        end
        tick();
        b_s_ack = 1'b1; b_s_rdt = 32'h0BADF00D;
        exp_dat_q.push_back(32'h0BADF00D);
        @(negedge clk);
        expd = exp_dat_q.pop_front();
        checks++;
        if (b_m_ack !== 2'b01 || b_m_err !== 2'b00 || b_m_rdt !== expd) begin
            errors++; $display("FAIL nowdog_ack got %b/%b/%h expected 01/00/%h", b_m_ack, b_m_err, b_m_rdt, expd);
        end
        tick();
        b_s_ack = 1'b0; b_m_cyc = '0; b_m_stb = '0;
        @(negedge clk);
        tick();
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] got;
        logic [AW-1:0] exp;
        int idle;
        bit ok;
        tick();
        m_adr[AW +: AW] = 16'h0900;
        m_cyc = 2'b10; m_stb = 2'b10;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++;
        if (s_cyc !== 1'b1 || s_adr !== 16'h0900) begin
            errors++; $display("FAIL rstmid_busy got cyc %b adr %h expected 1/0900", s_cyc, s_adr);
        end
        #2;
        s_ack = 1'b1;
        rstn = 1'b0;
        #1;
        checks++;
        if ({s_cyc, s_stb, m_ack, m_err} !== 6'b0) begin
            errors++; $display("FAIL rstmid_async got cyc %b stb %b ack %b err %b expected all 0", s_cyc, s_stb, m_ack, m_err);
        end
        m_adr[0 +: AW] = 16'h0A00;
        m_cyc = 2'b11; m_stb = 2'b11;
        tick();
        rstn = 1'b1; s_ack = 1'b0;
        exp_adr_q.push_back(16'h0A00);
        exp_adr_q.push_back(16'h0900);
        for (int t = 0; t < 2; t++) begin
            wait_grant(got, idle, ok);
            exp = exp_adr_q.pop_front();
            checks++;
            if (!ok || got !== exp || idle !== 1) begin
                errors++; $display("FAIL rstmid_grant %0d got adr %h idle %0d ok %0d expected %h/1/1", t, got, idle, ok, exp);
            end
            tick();
            s_ack = 1'b1;
            @(negedge clk);
            tick();
            s_ack = 1'b0;
            m_cyc[t] = 1'b0; m_stb[t] = 1'b0;
            @(negedge clk);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_block();
        test_watchdog();
        test_no_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
